// File: rtl/emboss_window_ctrl_if.sv
// Pixel-in and window-out handshake bundle for the emboss window controller.
// The slave modport is the controller side; the master modport is the source/filter side.
interface emboss_window_ctrl_if;
    logic [7:0] i_pixel;
    logic       i_pixel_valid;
    logic       o_pixel_ack;
    logic [7:0] o_win_1;
    logic [7:0] o_win_2;
    logic [7:0] o_win_3;
    logic       o_win_valid;
    logic       i_win_ack;

    modport slave (
        input  i_pixel, i_pixel_valid, i_win_ack,
        output o_pixel_ack, o_win_1, o_win_2, o_win_3, o_win_valid
    );

    modport master (
        output i_pixel, i_pixel_valid, i_win_ack,
        input  o_pixel_ack, o_win_1, o_win_2, o_win_3, o_win_valid
    );
endinterface

// File: rtl/emboss_window_ctrl.sv
// Builds vertical 3-pixel column windows from a raster pixel stream using two line buffers.
// Window is registered 1 cycle after pixel accept; input ack drops while a window is stalled.
module emboss_window_ctrl #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    emboss_window_ctrl_if.slave   win_if,
    output logic                  o_busy,
    output logic                  o_frame_done
);
    localparam int AW = $clog2(IMG_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic           win_vld_q, win_vld_d;
    logic [7:0]     win1_q, win2_q, win3_q;

    logic [7:0]     lb_a_q [IMG_WIDTH];
    logic [7:0]     lb_b_q [IMG_WIDTH];

    logic           pix_ack;
    logic           acc;
    logic           last_col;
    logic [AW-1:0]  col_idx;

    assign col_idx  = col_q[AW-1:0];
    assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
    assign pix_ack  = ((state_q == S_PRIME) || (state_q == S_RUN)) &&
                      (!win_vld_q || win_if.i_win_ack);
    assign acc      = win_if.i_pixel_valid && pix_ack;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        win_vld_d = win_vld_q;

        if (acc) begin
            if (last_col) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // A fresh window replaces the old one in the same cycle it is acked.
        if ((state_q == S_RUN) && acc) begin
            win_vld_d = 1'b1;
        end else if (win_if.i_win_ack) begin
            win_vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_PRIME;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_PRIME: begin
                if (acc && last_col && (row_q == ROW_W'(1))) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (acc && last_col && (row_q == ROW_W'(IMG_HEIGHT - 1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!win_vld_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                col_d   = '0;
                row_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            win_vld_q <= 1'b0;
            win1_q    <= '0;
            win2_q    <= '0;
            win3_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_vld_q <= win_vld_d;
            if ((state_q == S_RUN) && acc) begin
                win1_q <= lb_b_q[col_idx];
                win2_q <= lb_a_q[col_idx];
                win3_q <= win_if.i_pixel;
            end
        end
    end

    // Line buffers are never cleared; every frame re-primes them before use.
    always_ff @(posedge i_clk) begin
        if (acc) begin
            lb_b_q[col_idx] <= lb_a_q[col_idx];
            lb_a_q[col_idx] <= win_if.i_pixel;
        end
    end

    assign win_if.o_pixel_ack = pix_ack;
    assign win_if.o_win_valid = win_vld_q;
    assign win_if.o_win_1     = win1_q;
    assign win_if.o_win_2     = win2_q;
    assign win_if.o_win_3     = win3_q;
    assign o_busy             = (state_q != S_IDLE);
    assign o_frame_done       = (state_q == S_DONE);
endmodule

// File: tb/tb_emboss_window_ctrl.sv
// Randomized frame-level bench for emboss_window_ctrl on a 4x4 image.
module tb_emboss_window_ctrl;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NWIN = W * (H - 2);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    emboss_window_ctrl_if u_if ();

    emboss_window_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (4),
        .ROW_W     (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .win_if      (u_if),
        .o_busy      (busy),
        .o_frame_done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [23:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int base, input int k);
        return 8'((base + k) % 256);
    endfunction

    // Column triple for row r, column c: rows r-2, r-1, r of the same column.
    function automatic logic [23:0] win_of(input int base, input int r, input int c);
        return {pix(base, (r - 2) * W + c), pix(base, (r - 1) * W + c), pix(base, r * W + c)};
    endfunction

    task automatic run_frame(input int base, input int ack_mode, input bit gap,
                             input bit inj, input int abort_at);
        int nacc = 0;
        int nwin = 0;
        int t_last = -1;
        int stall = 0;
        bit stall_done = 0, first_pend = 0, prev_stall = 0;
        bit inj_run = 0, inj_drain = 0, finished = 0;
        bit acc, hs;
        logic [23:0] held, got_w;

        exp_q.delete();
        for (int r = 2; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back(win_of(base, r, c));

        start = 1'b1;
        u_if.i_pixel_valid = 1'b0;
        u_if.i_win_ack = 1'b1;
        u_if.i_pixel = pix(base, 0);
        held = '0;

        for (int t = 0; t < 3000 && !finished; t++) begin
            @(negedge clk);
            acc   = u_if.i_pixel_valid && u_if.o_pixel_ack;
            hs    = u_if.o_win_valid && u_if.i_win_ack;
            got_w = {u_if.o_win_1, u_if.o_win_2, u_if.o_win_3};

            if (t == 0) check_eq("busy_idle", busy, 0);
            else        check_eq("busy", busy, 1);
            check_eq("frame_done", done, (t_last >= 0 && t == t_last + 2));
            if (nacc < 2 * W) check_eq("prime_no_win", u_if.o_win_valid, 0);
            if (first_pend) begin
                check_eq("first_lat_vld", u_if.o_win_valid, 1);
                check_eq("first_lat_dat", got_w, exp_q[0]);
                first_pend = 0;
            end
            if (prev_stall) begin
                check_eq("hold_vld", u_if.o_win_valid, 1);
                check_eq("hold_dat", got_w, held);
            end
            prev_stall = u_if.o_win_valid && !u_if.i_win_ack;
            held = got_w;
            if (prev_stall) check_eq("stall_pixel_ack", u_if.o_pixel_ack, 0);
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check_eq("win_overflow", nwin + 1, NWIN);
                end else begin
                    check_eq("win", got_w, exp_q.pop_front());
                    nwin++;
                    if (exp_q.size() == 0) t_last = t;
                end
            end
            if (t_last >= 0 && t == t_last + 2) finished = 1;
            if (acc) begin
                if (nacc == 2 * W) first_pend = 1;
                nacc++;
            end

            @(posedge clk);
            #1;
            start = 1'b0;
            if (abort_at > 0 && nacc == abort_at) begin
                rst_n = 1'b0;
                u_if.i_pixel_valid = 1'b0;
                @(negedge clk);
                check_eq("abort_vld", u_if.o_win_valid, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            if (inj && !inj_run && nacc == 2 * W + 2) begin
                start = 1'b1;
                inj_run = 1;
            end
            if (inj && !inj_drain && nacc == NPIX) begin
                start = 1'b1;
                inj_drain = 1;
            end
            if (nacc >= NPIX)
                u_if.i_pixel_valid = 1'b0;
            else if (!(u_if.i_pixel_valid && !acc))
                u_if.i_pixel_valid = gap ? (t % 3 == 2) : 1'b1;
            u_if.i_pixel = pix(base, nacc);
            case (ack_mode)
                1: begin
                    if (!stall_done && nwin == 2) begin
                        stall = 5;
                        stall_done = 1;
                    end
                    u_if.i_win_ack = (stall == 0);
                    if (stall > 0) stall--;
                end
                2:       u_if.i_win_ack = 1'($urandom_range(0, 1));
                default: u_if.i_win_ack = 1'b1;
            endcase
        end
        check_eq("finished", finished, 1);
        check_eq("nwin", nwin, NWIN);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.i_pixel = '0;
        u_if.i_pixel_valid = 1'b0;
        u_if.i_win_ack = 1'b1;
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_win_vld", u_if.o_win_valid, 0);
        check_eq("rst_win", {u_if.o_win_1, u_if.o_win_2, u_if.o_win_3}, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pixel_ack", u_if.o_pixel_ack, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_eq("start_in_rst", busy, 0);
        @(posedge clk);
        #1;

        run_frame(1, 0, 0, 0, 0);
        run_frame(1, 1, 0, 0, 0);
        run_frame(1, 0, 0, 0, 11);
        run_frame(101, 0, 0, 0, 0);
        run_frame(1, 0, 1, 1, 0);
        run_frame(201, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            run_frame(int'($urandom_range(0, 255)), 2, 1'($urandom_range(0, 1)), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/emboss_window_ctrl.md
Name: emboss_window_ctrl

Overview:
Sequencing front-end for the 3-tap emboss X-filter. It accepts a raster-order 8-bit pixel stream and holds the two previous image lines in on-chip line buffers. For each pixel it presents the vertically aligned column triple (rows r-2, r-1, r) to the filter's i_pixel_1/2/3 inputs under valid/ack handshake. It also primes, frames and drains each image and signals frame completion.

Parameters:
IMG_WIDTH, 512, pixels per line (>=3)
IMG_HEIGHT, 512, lines per frame (>=3)
COL_W, 10, column counter width (>= clog2(IMG_WIDTH))
ROW_W, 10, row counter width (>= clog2(IMG_HEIGHT))

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle pulse; begins a frame (honoured only in IDLE)
i_pixel  in  8  input pixel, raster order
i_pixel_valid  in  1  input pixel valid
o_pixel_ack  out  1  input pixel accepted this cycle when high with i_pixel_valid
o_win_1  out  8  pixel from row r-2 (oldest); to filter i_pixel_1
o_win_2  out  8  pixel from row r-1; to filter i_pixel_2
o_win_3  out  8  pixel from row r (current); to filter i_pixel_3
o_win_valid  out  1  window triple valid; to filter i_pixel_valid
i_win_ack  in  1  downstream accept; from filter o_pixel_ack
o_busy  out  1  high in any state except IDLE
o_frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- One clock (i_clk). Reset asynchronous, active-low (i_rst_n). Reset forces state IDLE, row/col = 0, o_win_valid = 0, o_win_1/2/3 = 0, o_frame_done = 0, o_busy = 0. Line-buffer contents are not reset; they are always re-primed.
- Line buffers: lb_a (row r-1) and lb_b (row r-2), each IMG_WIDTH x 8. Read is asynchronous and indexed by col; write is synchronous.
- Accept condition: acc = i_pixel_valid & o_pixel_ack.
  - o_pixel_ack = (state==PRIME | state==RUN) & (~o_win_valid | i_win_ack). This is combinational.
  - In IDLE, DRAIN and DONE, o_pixel_ack = 0.
- On acc:
  - Write lb_b[col] <= lb_a[col] and lb_a[col] <= i_pixel.
  - col increments. At col==IMG_WIDTH-1, col wraps to 0 and row increments.
- Output register, RUN only:
  - On acc, {o_win_1,o_win_2,o_win_3} <= {lb_b[col], lb_a[col], i_pixel} (pre-write values) and o_win_valid <= 1.
  - Latency from accepted pixel to window valid is 1 cycle.
- o_win_valid clears on i_win_ack unless a new acc occurs in the same cycle. In that case it stays 1 and the data is replaced, giving full throughput of 1 window/cycle.
- o_win_* are held stable while o_win_valid=1 and i_win_ack=0.
- FSM:
  - IDLE: on i_start go to PRIME; row=col=0.
  - PRIME (rows 0,1): pixels are accepted into the line buffers; no window is produced. When the acc at row==1, col==IMG_WIDTH-1 occurs, go to RUN.
  - RUN (rows 2..IMG_HEIGHT-1): one window per accepted pixel. When the acc at row==IMG_HEIGHT-1, col==IMG_WIDTH-1 occurs, go to DRAIN.
  - DRAIN: wait until o_win_valid==0, i.e. the last window is acked; then go to DONE. If o_win_valid & i_win_ack already hold in the entry cycle, the next cycle sees o_win_valid=0 and moves on.
  - DONE: o_frame_done=1 for exactly this cycle; next state IDLE, with row=col=0.
- Windows per frame = IMG_WIDTH*(IMG_HEIGHT-2). The column edges carry no special handling: the filter's horizontal history spans line wrap, and that is accepted.
- i_start outside IDLE is ignored. i_start coincident with reset deassertion is ignored only if i_rst_n is still low that cycle.
- Reset mid-frame aborts immediately; no o_frame_done is generated. A subsequent i_start re-primes from row 0.
- i_pixel_valid without ack: the pixel is not consumed and counters hold. The source holds i_pixel stable.

Test Plan:
- W=4, H=4, pixels 1..16, i_win_ack tied 1 -> 8 windows, first {1,5,9}, last {8,12,16}; o_frame_done single pulse 2 cycles after pixel 16 accepted; o_busy low after it.
- Same frame, i_win_ack low for 5 cycles at window 3 ({3,7,11}) -> o_pixel_ack low during stall, window held stable, no window lost or duplicated, total still 8.
- During PRIME (pixels 1..8) -> o_win_valid never asserts; first o_win_valid exactly 1 cycle after pixel 9 accepted.
- Assert i_rst_n=0 after pixel 11 -> o_win_valid=0 and o_busy=0 in the reset cycle, no frame_done. Then i_start plus pixels 101..116 -> first window {101,105,109}.
- i_start pulsed in RUN and DRAIN -> ignored, counters unaffected. Gapped i_pixel_valid (1 of every 3 cycles) -> identical 8-window sequence.
- Back-to-back frames (i_start in the cycle after o_frame_done) -> second frame's windows contain no first-frame data.
